// File: rtl/fsm_run_monitor_if.sv
// fsm_run_monitor_if: detector inputs and statistics outputs of fsm_run_monitor
// master drives z/y/clear/ack; slave (the monitor) drives the counters, alarm, proto_err and hex
interface fsm_run_monitor_if #(parameter int CW = 8);
  logic z;
  logic [3:0] y;
  logic clear;
  logic ack;
  logic [CW-1:0] zero_hits;
  logic [CW-1:0] one_hits;
  logic [CW-1:0] run_len;
  logic [CW-1:0] max_run;
  logic alarm;
  logic proto_err;
  logic [6:0] hex;
  modport master(output z, y, clear, ack, input zero_hits, one_hits, run_len, max_run, alarm, proto_err, hex);
  modport slave(input z, y, clear, ack, output zero_hits, one_hits, run_len, max_run, alarm, proto_err, hex);
endinterface

// File: rtl/fsm_run_monitor.sv
// fsm_run_monitor: hit counters, run-length tracking, long-run alarm and 7-seg display for the run detector
// clk/reset plain ports (sync active-high reset); m: z, y, clear, ack in; zero_hits, one_hits, run_len, max_run, alarm, proto_err, hex out
module fsm_run_monitor #(
  parameter int CW = 8,
  parameter int ALARM_LEN = 16
) (
  input logic clk,
  input logic reset,
  fsm_run_monitor_if.slave m
);
  localparam logic [1:0] IDLE = 2'd0, WATCH = 2'd1, ALARM = 2'd2, HOLDOFF = 2'd3;
  localparam logic [CW-1:0] MAX = {CW{1'b1}};
  localparam logic [CW-1:0] AL1 = CW'(ALARM_LEN - 1);
  logic z_prev_q, z_prev_d;
  logic [CW-1:0] zero_hits_q, zero_hits_d, one_hits_q, one_hits_d;
  logic [CW-1:0] run_len_q, run_len_d, max_run_q, max_run_d;
  logic proto_err_q, proto_err_d;
  logic [1:0] state_q, state_d;
  logic [6:0] hex_q, hex_d;
  logic rise, zh_hit, oh_hit, err;
  always_comb begin
    z_prev_d = m.z;
    rise = m.z & ~z_prev_q;
    zh_hit = rise & (m.y == 4'd4);
    oh_hit = rise & (m.y == 4'd8);
    err = (m.y > 4'd8) | (m.z & (m.y != 4'd4) & (m.y != 4'd8));
    // a hit coinciding with clear lands on the freshly zeroed counter
    zero_hits_d = m.clear ? CW'(zh_hit) : zero_hits_q + CW'(zh_hit && zero_hits_q != MAX);
    one_hits_d = m.clear ? CW'(oh_hit) : one_hits_q + CW'(oh_hit && one_hits_q != MAX);
    run_len_d = !m.z ? '0 : !z_prev_q ? CW'(1) : run_len_q + CW'(run_len_q != MAX);
    max_run_d = (m.clear || run_len_d > max_run_q) ? run_len_d : max_run_q;
    proto_err_d = err | (proto_err_q & ~m.clear);
    // run_len_q lags the sample by one, so ALARM_LEN-1 means this is the ALARM_LEN-th high
    state_d = state_q == IDLE  ? (m.z ? WATCH : IDLE) :
              state_q == WATCH ? (!m.z ? IDLE : run_len_q == AL1 ? ALARM : WATCH) :
              state_q == ALARM ? (!m.ack ? ALARM : m.z ? HOLDOFF : IDLE) :
                                 (m.z ? HOLDOFF : IDLE);
    case (m.y)
      4'd0: hex_d = 7'h40;
      4'd1: hex_d = 7'h79;
      4'd2: hex_d = 7'h24;
      4'd3: hex_d = 7'h30;
      4'd4: hex_d = 7'h19;
      4'd5: hex_d = 7'h12;
      4'd6: hex_d = 7'h02;
      4'd7: hex_d = 7'h78;
      4'd8: hex_d = 7'h00;
      default: hex_d = 7'h3F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      z_prev_q <= 1'b0;
      zero_hits_q <= '0;
      one_hits_q <= '0;
      run_len_q <= '0;
      max_run_q <= '0;
      proto_err_q <= 1'b0;
      state_q <= IDLE;
      hex_q <= 7'h40;
    end else begin
      z_prev_q <= z_prev_d;
      zero_hits_q <= zero_hits_d;
      one_hits_q <= one_hits_d;
      run_len_q <= run_len_d;
      max_run_q <= max_run_d;
      proto_err_q <= proto_err_d;
      state_q <= state_d;
      hex_q <= hex_d;
    end
  end
  assign m.zero_hits = zero_hits_q;
  assign m.one_hits = one_hits_q;
  assign m.run_len = run_len_q;
  assign m.max_run = max_run_q;
  assign m.alarm = state_q == ALARM;
  assign m.proto_err = proto_err_q;
  assign m.hex = hex_q;
endmodule

// File: tb/tb_fsm_run_monitor.sv
// tb_fsm_run_monitor: directed table vectors plus alarm/saturation sequences for fsm_run_monitor
module tb_fsm_run_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fsm_run_monitor_if #(.CW(8)) a ();
  fsm_run_monitor_if #(.CW(4)) b ();
  fsm_run_monitor #(.CW(8), .ALARM_LEN(16)) dut_a (.clk(clk), .reset(reset), .m(a.slave));
  fsm_run_monitor #(.CW(4), .ALARM_LEN(8)) dut_b (.clk(clk), .reset(reset), .m(b.slave));
  typedef struct {
    logic z;
    logic [3:0] y;
    logic clr;
    logic ack;
    logic [7:0] zh, oh, rl, mr;
    logic al, pe;
    logic [6:0] hex;
  } vec_t;
  vec_t v[$];
  int passed = 0;
  int total = 0;
  function automatic vec_t mk(input logic z, input logic [3:0] y, input logic clr, input logic ack,
                              input logic [7:0] zh, input logic [7:0] oh, input logic [7:0] rl, input logic [7:0] mr,
                              input logic al, input logic pe, input logic [6:0] hex);
    vec_t r;
    r.z = z; r.y = y; r.clr = clr; r.ack = ack;
    r.zh = zh; r.oh = oh; r.rl = rl; r.mr = mr;
    r.al = al; r.pe = pe; r.hex = hex;
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask
  task automatic step_a(input logic z, input logic [3:0] y, input logic clr, input logic ack);
    a.z = z; a.y = y; a.clear = clr; a.ack = ack;
    @(posedge clk);
    #1;
  endtask
  task automatic step_b(input logic z, input logic [3:0] y);
    b.z = z; b.y = y;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] pack_a();
    return {23'd0, a.zero_hits, a.one_hits, a.run_len, a.max_run, a.alarm, a.proto_err, a.hex};
  endfunction
  initial begin
    a.z = 1'b1; a.y = 4'd8; a.clear = 1'b0; a.ack = 1'b0;
    b.z = 1'b0; b.y = 4'd0; b.clear = 1'b0; b.ack = 1'b0;
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 7'h40));
    v.push_back(mk(1, 4, 0, 0, 1, 1, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 1, 1, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 0, 0, 2, 1, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 2, 1, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 0, 0, 3, 1, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 8, 0, 0, 3, 1, 0, 1, 0, 0, 7'h00));
    v.push_back(mk(1, 8, 0, 0, 3, 2, 1, 1, 0, 0, 7'h00));
    v.push_back(mk(0, 8, 0, 0, 3, 2, 0, 1, 0, 0, 7'h00));
    v.push_back(mk(1, 8, 0, 0, 3, 3, 1, 1, 0, 0, 7'h00));
    v.push_back(mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0, 7'h40));
    v.push_back(mk(1, 4, 0, 0, 4, 3, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 4, 3, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 0, 0, 5, 3, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 5, 3, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 0, 0, 6, 3, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 6, 3, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 0, 0, 7, 3, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 4, 0, 0, 7, 3, 0, 1, 0, 0, 7'h19));
    v.push_back(mk(1, 4, 1, 0, 1, 0, 1, 1, 0, 0, 7'h19));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 7'h40));
    v.push_back(mk(0, 11, 0, 0, 1, 0, 0, 1, 0, 1, 7'h3F));
    v.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 7'h30));
    v.push_back(mk(1, 3, 0, 0, 0, 0, 1, 1, 0, 1, 7'h30));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7'h40));
    v.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 7'h24));
    v.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 7'h12));
    v.push_back(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 7'h02));
    v.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7'h78));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'h79));
    v.push_back(mk(0, 15, 0, 0, 0, 0, 0, 0, 0, 1, 7'h3F));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", pack_a(), {23'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 7'h40});
    reset = 1'b0;
    step_a(1, 8, 0, 0);
    chk("first_after_reset", pack_a(), {23'd0, 8'd0, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 7'h00});
    foreach (v[i]) begin
      step_a(v[i].z, v[i].y, v[i].clr, v[i].ack);
      chk($sformatf("vec%0d", i), pack_a(),
          {23'd0, v[i].zh, v[i].oh, v[i].rl, v[i].mr, v[i].al, v[i].pe, v[i].hex});
    end
    step_a(0, 8, 1, 0);
    chk("clear_err", {63'd0, a.proto_err}, 64'd0);
    for (int k = 1; k <= 20; k++) begin
      step_a(1, 8, 0, k == 18);
      chk($sformatf("run1_alarm_k%0d", k), {63'd0, a.alarm}, {63'd0, k == 16 || k == 17});
      chk($sformatf("run1_len_k%0d", k), {56'd0, a.run_len}, 64'(k));
    end
    step_a(0, 8, 0, 0);
    chk("gap_len", {55'd0, a.alarm, a.run_len}, 64'd0);
    for (int k = 1; k <= 16; k++) begin
      step_a(1, 8, 0, 0);
      chk($sformatf("run2_alarm_k%0d", k), {63'd0, a.alarm}, {63'd0, k == 16});
    end
    step_a(0, 8, 0, 0);
    chk("alarm_held_low_z", {55'd0, a.alarm, a.run_len}, {55'd0, 1'b1, 8'd0});
    step_a(0, 8, 0, 1);
    chk("ack_low_z", {63'd0, a.alarm}, 64'd0);
    for (int k = 1; k <= 16; k++) step_a(1, 8, 0, 0);
    chk("run3_alarm", {63'd0, a.alarm}, 64'd1);
    reset = 1'b1;
    step_a(1, 8, 1, 1);
    chk("reset_drops_alarm", pack_a(), {23'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 7'h40});
    reset = 1'b0;
    step_a(0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step_b(1, 4);
      chk($sformatf("sat_hits_k%0d", k), {60'd0, b.zero_hits}, 64'(k > 15 ? 15 : k));
      step_b(0, 4);
    end
    for (int k = 1; k <= 20; k++) begin
      step_b(1, 8);
      chk($sformatf("sat_run_k%0d", k), {56'd0, b.run_len, b.max_run}, {56'd0, 4'(k > 15 ? 15 : k), 4'(k > 15 ? 15 : k)});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
